// File: rtl/yuv444_to_422_pkg.sv
// Shared beat-type definitions for the YUV 4:4:4 -> 4:2:2 converter.
// Provides DTYPE_WIDTH, the beat-type codes and a small classifier
// that maps a raw dtype field onto the beat kinds the converter cares about.
package yuv444_to_422_pkg;

    localparam int DTYPE_WIDTH = 4;

    typedef enum logic [DTYPE_WIDTH-1:0] {
        DT_OTHER       = 4'd0,
        DT_ROW_START   = 4'd1,
        DT_ROW_END     = 4'd2,
        DT_PIXEL       = 4'd3,
        DT_FRAME_START = 4'd4,
        DT_FRAME_END   = 4'd5
    } dtype_e;

    typedef enum logic [1:0] {
        BK_OTHER     = 2'd0,
        BK_ROW_START = 2'd1,
        BK_ROW_END   = 2'd2,
        BK_PIXEL     = 2'd3
    } beat_kind_e;

    // Any code not explicitly recognised is treated as an opaque "other" beat.
    function automatic beat_kind_e classify(input logic [DTYPE_WIDTH-1:0] dtype);
        beat_kind_e kind;
        kind = BK_OTHER;
        if (dtype == DT_ROW_START)    kind = BK_ROW_START;
        else if (dtype == DT_ROW_END) kind = BK_ROW_END;
        else if (dtype == DT_PIXEL)   kind = BK_PIXEL;
        return kind;
    endfunction

endpackage

// File: rtl/yuv444_to_422_chroma_avg.sv
// chroma_avg: rounded signed average of two PIXEL_WIDTH two's-complement samples.
// Ports:
//   i_a, i_b : signed samples
//   o_avg    : (i_a + i_b + 1) >>> 1, computed one bit wider so it never overflows
module chroma_avg #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic signed [PIXEL_WIDTH-1:0] i_a,
    input  logic signed [PIXEL_WIDTH-1:0] i_b,
    output logic signed [PIXEL_WIDTH-1:0] o_avg
);

    function automatic logic signed [PIXEL_WIDTH-1:0] round_avg(
        input logic signed [PIXEL_WIDTH-1:0] a,
        input logic signed [PIXEL_WIDTH-1:0] b
    );
        logic signed [PIXEL_WIDTH:0] sum;
        logic signed [PIXEL_WIDTH:0] half;
        sum  = {a[PIXEL_WIDTH-1], a} + {b[PIXEL_WIDTH-1], b} + {{PIXEL_WIDTH{1'b0}}, 1'b1};
        half = sum >>> 1;
        // The halved sum always lies within the input range, so the top bit is redundant.
        return half[PIXEL_WIDTH-1:0];
    endfunction

    assign o_avg = round_avg(i_a, i_b);

endmodule

// File: rtl/yuv444_to_422.sv
// yuv444_to_422: converts a 4:4:4 pixel beat stream into 4:2:2 with one cycle latency.
// Even pixels carry averaged U, odd pixels carry averaged V on a single chroma output.
// Ports:
//   clk, reset (sync, active-high), enable (0 = bypass: co carries raw u)
//   dvi/dtypei/meta_datai : upstream beat valid, type, sideband
//   y, u, v               : upstream samples (u, v signed two's complement)
//   dvo/dtypeo/meta_datao : registered beat copies
//   yo, co, csel          : luma, offset-binary chroma, chroma select (0 = U, 1 = V)
//   clr_err, odd_row_err  : sticky odd-pixel-count row error and its clear
module yuv444_to_422
    import yuv444_to_422_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          dvi,
    input  logic [DTYPE_WIDTH-1:0]        dtypei,
    input  logic [15:0]                   meta_datai,
    input  logic [PIXEL_WIDTH-1:0]        y,
    input  logic signed [PIXEL_WIDTH-1:0] u,
    input  logic signed [PIXEL_WIDTH-1:0] v,
    output logic                          dvo,
    output logic [DTYPE_WIDTH-1:0]        dtypeo,
    output logic [15:0]                   meta_datao,
    output logic [PIXEL_WIDTH-1:0]        yo,
    output logic [PIXEL_WIDTH-1:0]        co,
    output logic                          csel,
    input  logic                          clr_err,
    output logic                          odd_row_err
);

    // Adding 2^(W-1) to a W-bit two's-complement value is the same as flipping its MSB.
    localparam logic [PIXEL_WIDTH-1:0] C_CHROMA_OFFSET = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};

    beat_kind_e                   w_kind;
    logic                         w_err_set;
    logic signed [PIXEL_WIDTH-1:0] w_avg_a;
    logic signed [PIXEL_WIDTH-1:0] w_avg_b;
    logic signed [PIXEL_WIDTH-1:0] w_avg;
    logic [PIXEL_WIDTH-1:0]       w_co;

    logic                         r_phase;
    logic                         r_new_row;
    logic signed [PIXEL_WIDTH-1:0] r_prev_u;
    logic signed [PIXEL_WIDTH-1:0] r_hold_v;

    assign w_kind = classify(dtypei);

    // Even pixel averages U with the previous odd pixel's U (or itself at row start);
    // odd pixel averages V with the V latched from its even partner.
    always_comb begin
        w_avg_a = u;
        w_avg_b = r_new_row ? u : r_prev_u;
        if (r_phase) begin
            w_avg_a = v;
            w_avg_b = r_hold_v;
        end
    end

    chroma_avg #(
        .PIXEL_WIDTH(PIXEL_WIDTH)
    ) u_chroma_avg (
        .i_a  (w_avg_a),
        .i_b  (w_avg_b),
        .o_avg(w_avg)
    );

    assign w_co      = $unsigned(w_avg) ^ C_CHROMA_OFFSET;
    assign w_err_set = dvi && (w_kind == BK_ROW_END) && r_phase && enable;

    // Output stage: every beat registers through, pixel beats also refresh yo/co/csel.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvo         <= 1'b0;
            dtypeo      <= '0;
            meta_datao  <= '0;
            yo          <= '0;
            co          <= '0;
            csel        <= 1'b0;
            odd_row_err <= 1'b0;
            r_phase     <= 1'b0;
            r_prev_u    <= '0;
            r_hold_v    <= '0;
            // A reset drops any half-finished pair; the next pixel starts a fresh pair.
            r_new_row   <= 1'b1;
        end else begin
            dvo        <= dvi;
            dtypeo     <= dtypei;
            meta_datao <= meta_datai;

            if (dvi) begin
                case (w_kind)
                    BK_ROW_START: begin
                        r_phase   <= 1'b0;
                        r_new_row <= 1'b1;
                    end
                    BK_ROW_END: begin
                        r_phase <= 1'b0;
                    end
                    BK_PIXEL: begin
                        r_phase   <= ~r_phase;
                        r_new_row <= 1'b0;
                        yo        <= y;
                        if (!r_phase) r_hold_v <= v;
                        else          r_prev_u <= u;
                        if (enable) begin
                            co   <= w_co;
                            csel <= r_phase;
                        end else begin
                            co   <= $unsigned(u);
                            csel <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            // Set has priority over clear.
            if (w_err_set)    odd_row_err <= 1'b1;
            else if (clr_err) odd_row_err <= 1'b0;
        end
    end

endmodule

// File: doc/yuv444_to_422.md
YUV444_TO_422 -- requirements
Module: yuv444_to_422

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, giving the per-channel sample width.
REQ-002 SHALL have port clk, input, 1, the single clock. All state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1; 0 selects bypass mode.
REQ-005 SHALL have the upstream beat ports, all inputs:
- dvi, 1: beat valid.
- dtypei, DTYPE_WIDTH: beat type.
- meta_datai, 16: sideband data.
REQ-006 SHALL have the upstream sample ports, all inputs, PIXEL_WIDTH each:
- y: unsigned luma.
- u: signed two's-complement chroma, no offset applied.
- v: signed two's-complement chroma, no offset applied.
REQ-007 SHALL have the downstream beat ports, all outputs:
- dvo, 1; dtypeo, DTYPE_WIDTH; meta_datao, 16.
REQ-008 SHALL have the downstream sample ports, all outputs:
- yo, PIXEL_WIDTH: luma.
- co, PIXEL_WIDTH: offset-binary chroma.
- csel, 1: 0 = co carries U, 1 = co carries V.
REQ-009 SHALL have port clr_err, input, 1, which clears odd_row_err.
REQ-010 SHALL have port odd_row_err, output, 1, a sticky flag set when a row ends with an unpaired pixel.

Function
REQ-011 Beats SHALL be classified as row-start, row-end, pixel or other using the shared dtypes definitions.
REQ-012 Every beat SHALL appear at the output exactly one cycle after input:
- dvo, dtypeo and meta_datao are registered copies of the inputs.
- There are no bubbles, no reordering and no backpressure.
REQ-013 A pair-phase bit SHALL track pixel position within the row:
- Cleared by reset and by any row-start beat with dvi=1.
- Toggled by each pixel beat with dvi=1.
- Held when dvi=0.
REQ-014 A prev_u register SHALL hold the u value of the most recent odd-phase pixel in the current row. An even pixel of a new row SHALL use its own u as prev_u.
REQ-015 An even-phase pixel (enable=1) SHALL output:
- yo = y.
- co = ((u + prev_u + 1) >>> 1) + 2^(PIXEL_WIDTH-1), computed with (PIXEL_WIDTH+1)-bit signed arithmetic.
- csel = 0.
- Its v is latched into hold_v.
REQ-016 An odd-phase pixel (enable=1) SHALL output:
- yo = y.
- co = ((v + hold_v + 1) >>> 1) + 2^(PIXEL_WIDTH-1).
- csel = 1.
- prev_u is updated to u.
REQ-017 The averages SHALL not overflow. The offset add SHALL equal an inversion of the MSB, with no clamping required.
REQ-018 For non-pixel beats, yo, co and csel SHALL hold their previous values.
REQ-019 With enable=0:
- yo = y, co = u, csel = 0 for every beat.
- Phase, prev_u and hold_v still update.
- odd_row_err is not set.
REQ-020 A row-end beat arriving with phase=1 (an odd pixel count) SHALL set odd_row_err and clear the phase.
REQ-021 If clr_err and a set condition occur in the same cycle, set SHALL win.
REQ-022 Beats with dvi=0 SHALL not alter phase, prev_u, hold_v or odd_row_err. Outputs SHALL still register (dvo=0).

Reset
REQ-023 On a reset cycle, the following SHALL be cleared to 0: dvo, dtypeo, meta_datao, yo, co, csel, odd_row_err, phase, prev_u and hold_v.
REQ-024 Reset asserted mid-row SHALL discard the pending pair. The first pixel after reset is even-phase.

Structure
REQ-025 Beat-type codes and DTYPE_WIDTH SHALL come from the shared dtypes definitions. The offset constant 2^(PIXEL_WIDTH-1) SHALL be a local derived constant.
REQ-026 One sub-module, chroma_avg, SHALL compute the rounded signed average of two PIXEL_WIDTH samples.

Verification
REQ-027 PIXEL_WIDTH=8, enable=1. Stimulus: row-start, then (y,u,v) = (10,20,-30), (11,40,-50). Required outputs:
- (yo=10, co=148, csel=0)
- (yo=11, co=88, csel=1)
REQ-028 Continue the same row with (12,-7,0), (13,5,3). Required outputs:
- (12, co=145, csel=0)
- (13, co=130, csel=1)
REQ-029 Extremes: pixel pair (0,-128,-128), (0,-128,-128) -> co=0, 0. Pixel pair (255,127,127), (255,127,127) -> co=255, 255.
REQ-030 Row of 3 pixels then row-end -> odd_row_err=1 on the cycle after row-end. Assert clr_err -> 0. Next row-start -> phase=0.
REQ-031 dvi gaps of 0-3 random cycles inside a row SHALL produce the same outputs as the gapless case, each beat with latency 1.
REQ-032 Reset asserted between the even and odd pixel: the next pixel is even, with csel=0, and all outputs are 0 on the reset cycle. Toggling enable=0 -> co equals the raw u.
